ls_tag_ctrl: RTL

//  Fully-associative tag controller that sits directly upstream of lru.

---
 rtl/ls_tag_pkg.sv | 34 +++
 rtl/ls_tag_match.sv | 32 +++
 rtl/ls_tag_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ls_tag_pkg.sv
// Shared definitions for the load/store tag controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: request/lru op codes, FSM state encoding, one-hot helpers.
// Helpers accept vectors up to 32 bits wide, so NUM_WAYS is limited to 32.
package ls_tag_pkg;

  localparam logic [1:0] OP_NOP        = 2'b00;
  localparam logic [1:0] OP_LOAD       = 2'b01;
  localparam logic [1:0] OP_STORE      = 2'b10;
  localparam logic [1:0] OP_INVALIDATE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index of the set bit; ORing the indices keeps it cheap and is exact
  // whenever the input really is one-hot.
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] vec);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/ls_tag_match.sv
// Combinational fully-associative tag compare across all ways.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle.
// Ports: i_tags/i_valid (way storage), i_tag (lookup key),
//        o_hit_vec (per-way match), o_hit (any match), o_hit_idx (encoded match).
module ls_tag_match #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 20
) (
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] i_tags,
  input  logic [NUM_WAYS-1:0]            i_valid,
  input  logic [TAG_W-1:0]               i_tag,
  output logic [NUM_WAYS-1:0]            o_hit_vec,
  output logic                           o_hit,
  output logic [$clog2(NUM_WAYS)-1:0]    o_hit_idx
);
  import ls_tag_pkg::*;

  localparam int IDX_W = $clog2(NUM_WAYS);

  always_comb begin
    o_hit_vec = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      o_hit_vec[i] = i_valid[i] && (i_tags[i] == i_tag);
    end
  end

  // Tags are kept unique by construction, so hit_vec is 0- or 1-hot.
  assign o_hit     = |o_hit_vec;
  assign o_hit_idx = IDX_W'(onehot_to_idx(32'(o_hit_vec)));

endmodule

// File: rtl/ls_tag_ctrl.sv
// Fully-associative tag controller feeding the lru block (IDLE->LOOKUP->RESP).
// Latency: response valid 2 cycles after request handshake; max 1 request / 3 cycles.
// Backpressure: req_ready_o only in IDLE; response held stable until rsp_ready_i.
// Ports: req_* (request in), rsp_* (response out), ls_* (op stream to lru),
//        lru_valid_i/lru_way_i (one-hot victim from lru, sampled only in LOOKUP).
// Optional macro LS_TAG_CTRL_PERF_CNT_EN adds saturating hit_cnt_o/miss_cnt_o.
module ls_tag_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_op_i,
  input  logic [TAG_W-1:0]            req_tag_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        rsp_hit_o,
  output logic [$clog2(NUM_WAYS)-1:0] rsp_way_o,
  output logic                        rsp_err_o,
  output logic                        ls_valid_o,
  output logic [1:0]                  ls_op_o,
  output logic [$clog2(NUM_WAYS)-1:0] ls_way_o,
  input  logic                        lru_valid_i,
  input  logic [NUM_WAYS-1:0]         lru_way_i
`ifdef LS_TAG_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]                 hit_cnt_o,
  output logic [15:0]                 miss_cnt_o
`endif
);
  import ls_tag_pkg::*;

  localparam int IDX_W = $clog2(NUM_WAYS);

  state_t                         r_state, w_state_nxt;
  logic [1:0]                     r_op;
  logic [TAG_W-1:0]               r_tag;
  logic [NUM_WAYS-1:0]            r_valid, w_valid_nxt;
  logic [NUM_WAYS-1:0][TAG_W-1:0] r_tags;
  logic                           r_rsp_hit, w_rsp_hit;
  logic                           r_rsp_err, w_rsp_err;
  logic [IDX_W-1:0]               r_rsp_way, w_rsp_way;
  logic                           w_wr_en;
  logic [NUM_WAYS-1:0]            w_hit_vec;
  logic                           w_hit;
  logic [IDX_W-1:0]               w_hit_idx;
  logic                           w_victim_ok;
  logic [IDX_W-1:0]               w_victim_idx;
  logic                           w_req_fire;

  ls_tag_match #(.NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W)) u_match (
    .i_tags    (r_tags),
    .i_valid   (r_valid),
    .i_tag     (r_tag),
    .o_hit_vec (w_hit_vec),
    .o_hit     (w_hit),
    .o_hit_idx (w_hit_idx)
  );

  // Ready is masked by reset so the requester never sees it while held in reset.
  assign req_ready_o  = (r_state == IDLE) && reset_n;
  assign rsp_valid_o  = (r_state == RESP);
  assign rsp_hit_o    = r_rsp_hit;
  assign rsp_way_o    = r_rsp_way;
  assign rsp_err_o    = r_rsp_err;
  assign w_req_fire   = req_valid_i && req_ready_o;
  assign w_victim_ok  = lru_valid_i && is_onehot(32'(lru_way_i));
  assign w_victim_idx = IDX_W'(onehot_to_idx(32'(lru_way_i)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_op      <= OP_NOP;
      r_tag     <= '0;
      r_valid   <= '0;
      r_rsp_hit <= 1'b0;
      r_rsp_way <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_rsp_hit <= w_rsp_hit;
      r_rsp_way <= w_rsp_way;
      r_rsp_err <= w_rsp_err;
      if (w_req_fire) begin
        r_op  <= req_op_i;
        r_tag <= req_tag_i;
      end
    end
  end

  // Tag storage carries no reset; the valid vector alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_tags[w_victim_idx] <= r_tag;
  end

  always_comb begin
    w_state_nxt = r_state;
    ls_valid_o  = 1'b0;
    ls_op_o     = OP_NOP;
    ls_way_o    = '0;
    w_rsp_hit   = r_rsp_hit;
    w_rsp_way   = r_rsp_way;
    w_rsp_err   = r_rsp_err;
    w_valid_nxt = r_valid;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_fire) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        w_state_nxt = RESP;
        w_rsp_hit   = 1'b0;
        w_rsp_way   = '0;
        w_rsp_err   = 1'b0;
        case (r_op)
          OP_LOAD, OP_STORE: begin
            if (w_hit) begin
              // Any hit, load or store, is only a recency touch for lru.
              ls_valid_o = 1'b1;
              ls_op_o    = OP_LOAD;
              ls_way_o   = w_hit_idx;
              w_rsp_hit  = 1'b1;
              w_rsp_way  = w_hit_idx;
            end else if (r_op == OP_STORE) begin
              // Allocation request; lru answers with its victim this same cycle.
              ls_valid_o = 1'b1;
              ls_op_o    = OP_STORE;
              if (w_victim_ok) begin
                w_wr_en     = 1'b1;
                w_valid_nxt = r_valid | lru_way_i;
                w_rsp_way   = w_victim_idx;
              end else begin
                w_rsp_err   = 1'b1;
              end
            end
          end
          OP_INVALIDATE: begin
            if (w_hit) begin
              ls_valid_o  = 1'b1;
              ls_op_o     = OP_INVALIDATE;
              ls_way_o    = w_hit_idx;
              w_rsp_hit   = 1'b1;
              w_rsp_way   = w_hit_idx;
              w_valid_nxt = r_valid & ~w_hit_vec;
            end
          end
          default: ;
        endcase
      end
      RESP: begin
        if (rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef LS_TAG_CTRL_PERF_CNT_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  logic        w_cnt_en;

  assign w_cnt_en = (r_state == LOOKUP) && ((r_op == OP_LOAD) || (r_op == OP_STORE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_cnt_en) begin
      if (w_hit && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (!w_hit && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
